// File: rtl/debounce_pkg.sv
// Shared constants for the debounce bank.
//   DEFAULT_THRESH : default number of stable sync-stage cycles before a level change
//   DEFAULT_CNT_W  : default stability counter width
//   NUM_CH         : number of debounced channels
package debounce_pkg;

    localparam int unsigned DEFAULT_THRESH = 10000;
    localparam int unsigned DEFAULT_CNT_W  = 16;
    localparam int unsigned NUM_CH         = 8;

endpackage

// File: rtl/debounce_cell.sv
// Single-channel debouncer: 2-flop synchronizer, stability counter, registered
// level and registered one-cycle rise/fall pulses.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   din   : raw asynchronous input
//   level : debounced level
//   rise  : one-cycle pulse, coincident with the cycle after level goes 0->1
//   fall  : one-cycle pulse, coincident with the cycle after level goes 1->0
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int unsigned THRESH = DEFAULT_THRESH,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] ThreshM1 = CNT_W'(THRESH - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s2_q == level_q) begin
            // Agreement (or a bounce back) restarts the stability window.
            cnt_d = '0;
        end else if (cnt_q == ThreshM1) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Pulses register together with the level update, so they are high
        // for exactly the cycle following it.
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of NUM_CH independent debouncers plus a wrapping press counter on channel 0.
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   din       : raw asynchronous pad inputs, one per channel
//   level     : debounced levels
//   rise      : per-channel one-cycle rising-edge pulses
//   fall      : per-channel one-cycle falling-edge pulses
//   press_cnt : count of rise[0] events, wraps at 8 bits
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned THRESH = DEFAULT_THRESH,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [7:0]        press_cnt
);

    logic [7:0] press_cnt_q, press_cnt_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_cell #(
            .THRESH (THRESH),
            .CNT_W  (CNT_W)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (rise[0]) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_cnt_q <= 8'd0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_cnt = press_cnt_q;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter THRESH, default 16'd10000: consecutive sync-stage cycles an input must differ from its debounced level before the level changes; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16: stability counter width; THRESH SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 din  input  8  raw asynchronous pad inputs (ui_in), one bit per channel.
REQ-006 level  output  8  debounced stable level per channel; this is the signal consumed downstream in place of the raw pad.
REQ-007 rise  output  8  one-cycle pulse per channel when level goes 0->1.
REQ-008 fall  output  8  one-cycle pulse per channel when level goes 1->0.
REQ-009 press_cnt  output  8  count of rise events on channel 0, wrapping.

Function
REQ-010 Each channel SHALL pass din through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-011 Each channel SHALL hold a CNT_W-bit counter cnt and a registered level bit.
REQ-012 When s2 == level, cnt SHALL load 0 on the next edge; a single-cycle bounce restarts the count.
REQ-013 When s2 != level and cnt < THRESH-1, cnt SHALL increment by 1.
REQ-014 When s2 != level and cnt == THRESH-1, level SHALL load s2 and cnt SHALL load 0 on that edge.
REQ-015 Latency: din first sampled at edge N and held stable SHALL make level change at edge N+1+THRESH (THRESH=1: level change at N+2).
REQ-016 rise/fall SHALL be registered, asserted for exactly the single cycle following the level update, never both high on one channel.
REQ-017 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-018 press_cnt SHALL increment on every cycle rise[0] is high, wrapping 8'hFF -> 8'h00.
REQ-019 A din pulse shorter than THRESH sync-stage cycles SHALL produce no level change and no pulse.
REQ-020 cnt SHALL never exceed THRESH-1; no counter overflow path exists.

Reset
REQ-021 While rst_n is low at a clock edge, s1, s2, cnt, level, rise, fall, press_cnt SHALL all load 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted during or on the cycle after reset.
REQ-023 If din is 1 when reset releases, level SHALL rise per REQ-015 with a normal rise pulse (counted in press_cnt for channel 0).

Structure
REQ-024 Shared package debounce_pkg SHALL hold DEFAULT_THRESH, DEFAULT_CNT_W and NUM_CH = 8.
REQ-025 Per-channel logic (sync, counter, level, edge pulses) SHALL live in sub-module debounce_cell, instantiated NUM_CH times by debounce_bank; press_cnt lives in debounce_bank.
REQ-026 All state SHALL be edge-triggered on clk; no latches, no derived clocks, no asynchronous reset paths.

Verification (THRESH=4)
REQ-027 Reset, din=8'h00 held 20 cycles -> level=0, rise=fall=0, press_cnt=0 throughout.
REQ-028 din[0] 0->1 sampled at edge N, held -> level[0]=1 after edge N+5, rise[0] high exactly one cycle, press_cnt=1.
REQ-029 din[3] toggled 1,0,1,0 with 3-cycle high phases -> level[3] stays 0, no rise/fall pulses.
REQ-030 din=8'hFF at once, held -> all level bits rise on the same edge, rise=8'hFF one cycle; then din=8'h00 -> fall=8'hFF one cycle.
REQ-031 256 clean press/release cycles on din[0] -> press_cnt returns to 8'h00; 257th press -> 8'h01.
REQ-032 rst_n low for one edge while din[1] count is at 2 -> cnt cleared, level[1]=0, no pulse; release with din[1]=1 held -> rise[1] at reset-release edge+5.
